fetch_buffer: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register, replacing the bare PC + instr_memory pairing. It owns the fetch PC and issues sequential requests to instruction memory over a valid/ready request channel with variable-latency, in-order responses. A DEPTH-entry in-order buffer holds {pc, instr} pairs for the IF/ID stage. Branch redirects from ID flush the buffer and discard any stale in-flight responses.

---
 rtl/fetch_buffer.sv | 122 ++++++++++++
 tb/tb_fetch_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests to
// instruction memory and buffers {pc, instr} pairs for the IF/ID stage.
module fetch_buffer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr
);

  localparam int           PW      = $clog2(DEPTH);
  localparam int           CW      = PW + 1;
  localparam logic [CW:0]  DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]          head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CW-1:0]          occ_q, occ_d, pend_q, pend_d, disc_q, disc_d;
  logic [CW-1:0]          disc_base;
  logic [DEPTH-1:0]       filled_q, filled_d;
  logic [ADDR_WIDTH-1:0]  pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic                   accept, pop, drop, fill;

  // In-flight cap counts stale requests too, so a burst of redirects cannot overrun memory
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, occ_q} + {1'b0, disc_q}) < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pop            = filled_q[head_q] && out_ready && !redirect_valid;
  assign drop           = imem_resp_valid && (disc_q != '0);
  assign fill           = imem_resp_valid && (disc_q == '0) && (pend_q != '0);
  assign disc_base      = disc_q + pend_q;

  assign out_valid = filled_q[head_q];
  assign out_pc    = out_valid ? pc_q[head_q]    : '0;
  assign out_instr = out_valid ? instr_q[head_q] : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    occ_d      = occ_q;
    pend_d     = pend_q;
    disc_d     = disc_q;
    filled_d   = filled_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head_d     = '0;
      alloc_d    = '0;
      fill_d     = '0;
      occ_d      = '0;
      pend_d     = '0;
      filled_d   = '0;
      // Every unfilled entry becomes a stale response; one arriving now is already consumed
      disc_d     = disc_base - ((imem_resp_valid && (disc_base != '0)) ? CW'(1) : CW'(0));
    end else begin
      fetch_pc_d = accept ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
      alloc_d    = accept ? alloc_q + PW'(1) : alloc_q;
      fill_d     = fill   ? fill_q  + PW'(1) : fill_q;
      head_d     = pop    ? head_q  + PW'(1) : head_q;
      occ_d      = occ_q  + (accept ? CW'(1) : CW'(0)) - (pop  ? CW'(1) : CW'(0));
      pend_d     = pend_q + (accept ? CW'(1) : CW'(0)) - (fill ? CW'(1) : CW'(0));
      disc_d     = drop ? disc_q - CW'(1) : disc_q;
      for (int i = 0; i < DEPTH; i++) begin
        if (fill && (fill_q == PW'(i))) begin
          filled_d[i] = 1'b1;
        end else if (pop && (head_q == PW'(i))) begin
          filled_d[i] = 1'b0;
        end else begin
          filled_d[i] = filled_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      occ_q      <= '0;
      pend_q     <= '0;
      disc_q     <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      disc_q     <= disc_d;
      filled_q   <= filled_d;
    end
  end

  // Payload storage needs no reset: it is only visible through the filled flags
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q[alloc_q] <= fetch_pc_q;
    end
    if (fill && !redirect_valid) begin
      instr_q[fill_q] <= imem_resp_instr;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: a queue-based model of the fetch stream
// plus a variable-latency in-order memory.
module tb_fetch_buffer;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid_i;
  logic [AW-1:0] redirect_pc_i;
  logic          imem_req_valid_o;
  logic          imem_req_ready_i;
  logic [AW-1:0] imem_req_addr_o;
  logic          imem_resp_valid_i;
  logic [IW-1:0] imem_resp_instr_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [AW-1:0] out_pc_o;
  logic [IW-1:0] out_instr_o;

  always #5 clk = ~clk;

  fetch_buffer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid_i), .redirect_pc(redirect_pc_i),
    .imem_req_valid(imem_req_valid_o), .imem_req_ready(imem_req_ready_i),
    .imem_req_addr(imem_req_addr_o),
    .imem_resp_valid(imem_resp_valid_i), .imem_resp_instr(imem_resp_instr_i),
    .out_valid(out_valid_o), .out_ready(out_ready_i),
    .out_pc(out_pc_o), .out_instr(out_instr_o)
  );

  typedef struct {logic [AW-1:0] pc; bit filled;} ent_t;
  typedef struct {logic [AW-1:0] addr; int due;} mreq_t;

  ent_t          mq[$];
  mreq_t         memq[$];
  int            stale_n, cyc, last_due, lat_lo, lat_hi, dut_pops;
  logic [AW-1:0] m_pc, hold_a;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    memq.delete();
    stale_n  = 0;
    m_pc     = 32'h0;
    last_due = cyc - 1;
  endtask

  task automatic step(input bit rdr, input logic [AW-1:0] rpc, input bit ordy, input bit qrdy);
    bit  exp_v, acc, pop, resp, hv;
    int  unf, idx, due;
    redirect_valid_i  = rdr;
    redirect_pc_i     = rpc;
    out_ready_i       = ordy;
    imem_req_ready_i  = qrdy;
    resp              = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_resp_valid_i = resp;
    imem_resp_instr_i = resp ? instr_of(memq[0].addr) : 32'h0;
    #1;
    exp_v = !rdr && ((mq.size() + stale_n) < DEPTH);
    hv    = (mq.size() > 0) && mq[0].filled;
    chk("req_valid", 64'(imem_req_valid_o), 64'(exp_v));
    if (exp_v) chk("req_addr", 64'(imem_req_addr_o), 64'(m_pc));
    chk("out_valid", 64'(out_valid_o), 64'(hv));
    if (hv) begin
      chk("out_pc", 64'(out_pc_o), 64'(mq[0].pc));
      chk("out_instr", 64'(out_instr_o), 64'(instr_of(mq[0].pc)));
    end else begin
      chk("out_pc_empty", 64'(out_pc_o), 64'h0);
      chk("out_instr_empty", 64'(out_instr_o), 64'h0);
    end
    if (out_valid_o && ordy && !rdr) dut_pops++;
    acc = exp_v && qrdy;
    pop = !rdr && ordy && hv;
    @(posedge clk);
    cyc++;
    if (resp) void'(memq.pop_front());
    if (acc) begin
      due = cyc + $urandom_range(lat_hi, lat_lo) - 1;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{m_pc, due});
    end
    if (rdr) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      stale_n = stale_n + unf - (resp ? 1 : 0);
      mq.delete();
      m_pc = {rpc[AW-1:2], 2'b00};
    end else begin
      if (resp) begin
        if (stale_n > 0) begin
          stale_n--;
        end else begin
          idx = -1;
          foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
          n_cmp++;
          assert (idx >= 0) else begin
            n_bad++;
            $error("FAIL protocol: observed response with no unfilled entry, expected none");
          end
          if (idx >= 0) mq[idx].filled = 1'b1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'h0; imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0; imem_resp_instr_i = 32'h0; out_ready_i = 1'b0;
    cyc = 0; dut_pops = 0; lat_lo = 1; lat_hi = 1;
    model_reset();
    #3;
    chk("rst_req_valid", 64'(imem_req_valid_o), 64'h0);
    chk("rst_req_addr", 64'(imem_req_addr_o), 64'h0);
    chk("rst_out_valid", 64'(out_valid_o), 64'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Fill the buffer with a 1-cycle memory while IF/ID stalls
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("full_out_valid", 64'(out_valid_o), 64'h1);
    chk("full_out_pc", 64'(out_pc_o), 64'h0);
    chk("full_req_valid", 64'(imem_req_valid_o), 64'h0);

    // Streaming: one instruction per cycle, no bubbles
    dut_pops = 0;
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stream_pops", 64'(dut_pops), 64'd16);

    // Memory back-pressure: address must hold until accepted
    hold_a = m_pc;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("hold_valid", 64'(imem_req_valid_o), 64'h1);
      chk("hold_addr", 64'(imem_req_addr_o), 64'(hold_a));
    end

    // Redirect with 3-cycle memory and requests outstanding
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h203, 1'b1, 1'b1);
    chk("redir_addr", 64'(imem_req_addr_o), 64'h200);
    for (int k = 0; k < 30 && !out_valid_o; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("redir_valid", 64'(out_valid_o), 64'h1);
    chk("redir_pc", 64'(out_pc_o), 64'h200);
    chk("redir_instr", 64'(out_instr_o), 64'(instr_of(32'h200)));

    // Redirect coinciding with a response, then a second redirect
    for (int k = 0; k < 20 && !((memq.size() > 0) && (memq[0].due <= cyc)); k++)
      step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    step(1'b1, 32'h400, 1'b1, 1'b1);
    for (int k = 0; k < 30 && !out_valid_o; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("redir2_valid", 64'(out_valid_o), 64'h1);
    chk("redir2_pc", 64'(out_pc_o), 64'h400);

    // Random traffic: latencies 1..4, random back-pressure and redirects
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++)
      step(($urandom % 16) == 0, $urandom, $urandom_range(1, 0) == 1, ($urandom % 4) != 0);

    // Mid-stream reset: outputs clear before any clock edge
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mrst_out_valid", 64'(out_valid_o), 64'h0);
    chk("mrst_out_pc", 64'(out_pc_o), 64'h0);
    chk("mrst_out_instr", 64'(out_instr_o), 64'h0);
    chk("mrst_req_valid", 64'(imem_req_valid_o), 64'h0);
    chk("mrst_req_addr", 64'(imem_req_addr_o), 64'h0);
    @(posedge clk); #1;
    model_reset();
    imem_resp_valid_i = 1'b0;
    rst = 1'b0;
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 60; i++)
      step(($urandom % 20) == 0, $urandom, $urandom_range(1, 0) == 1, ($urandom % 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
